// File: rtl/hynoc_egress_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : hynoc_egress_arbiter
// Description : N-input packet-locking round-robin arbiter driving one router
//               egress link, throttled by the downstream FIFO fill level.
// Revision    : 1.0 - initial release
// ============================================================================
module hynoc_egress_arbiter #(
    parameter int NB_PORTS        = 5,
    parameter int LOG2_FIFO_DEPTH = 5,
    parameter int PAYLOAD_WIDTH   = 32,
    parameter int FLIT_WIDTH      = PAYLOAD_WIDTH + 1,
    parameter int LEVEL_MARGIN    = 2
) (
    input  logic                           router_clk,
    input  logic                           router_srst,
    input  logic [NB_PORTS-1:0]            req_valid,
    input  logic [NB_PORTS*FLIT_WIDTH-1:0] req_data,
    output logic [NB_PORTS-1:0]            req_read,
    output logic                           egress_write,
    output logic [FLIT_WIDTH-1:0]          egress_data,
    input  logic [LOG2_FIFO_DEPTH:0]       egress_fifo_level,
    output logic [NB_PORTS-1:0]            grant,
    output logic                           busy
);

    localparam int                  c_PTR_W     = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;
    localparam int                  c_LVL_W     = LOG2_FIFO_DEPTH + 2;
    localparam logic [c_LVL_W-1:0]  c_DEPTH     = {2'b01, {LOG2_FIFO_DEPTH{1'b0}}};
    localparam logic [c_LVL_W-1:0]  c_MARGIN    = c_LVL_W'(LEVEL_MARGIN);
    localparam logic [c_PTR_W-1:0]  c_LAST_PORT = c_PTR_W'(NB_PORTS - 1);
    localparam logic [NB_PORTS-1:0] c_ONE       = {{(NB_PORTS-1){1'b0}}, 1'b1};

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_XFER = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [NB_PORTS-1:0]   r_grant;
    logic [NB_PORTS-1:0]   w_grant_nxt;
    logic [c_PTR_W-1:0]    r_owner;
    logic [c_PTR_W-1:0]    w_owner_nxt;
    logic [c_PTR_W-1:0]    r_rr_ptr;
    logic [c_PTR_W-1:0]    w_rr_nxt;
    logic                  r_egress_write;
    logic [FLIT_WIDTH-1:0] r_egress_data;

    logic [FLIT_WIDTH-1:0] w_heads [NB_PORTS];
    logic [FLIT_WIDTH-1:0] w_head;
    logic [c_LVL_W-1:0]    w_free;
    logic                  w_space_ok;
    logic                  w_pop;
    logic [c_PTR_W-1:0]    w_winner;

    for (genvar gi = 0; gi < NB_PORTS; gi++) begin : g_unpack
        assign w_heads[gi] = req_data[gi*FLIT_WIDTH +: FLIT_WIDTH];
    end

    // A level above the depth makes w_free negative; its sign bit vetoes the read.
    assign w_free     = c_DEPTH - {1'b0, egress_fifo_level};
    assign w_space_ok = ~w_free[c_LVL_W-1] && (w_free > c_MARGIN);

    function automatic logic [c_PTR_W-1:0] f_next_winner(
        input logic [NB_PORTS-1:0] valid,
        input logic [c_PTR_W-1:0]  ptr
    );
        logic [c_PTR_W-1:0] idx;
        logic [c_PTR_W-1:0] win;
        logic               found;
        idx   = ptr;
        win   = ptr;
        found = 1'b0;
        for (int k = 0; k < NB_PORTS; k++) begin
            if (idx == c_LAST_PORT) idx = '0;
            else                    idx = idx + c_PTR_W'(1);
            if (!found && valid[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign w_winner = f_next_winner(req_valid, r_rr_ptr);
    assign w_head   = w_heads[r_owner];
    assign w_pop    = (r_state == c_XFER) && req_valid[r_owner] && w_space_ok && !router_srst;
    assign req_read = w_pop ? r_grant : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            c_IDLE: begin
                if (|req_valid) begin
                    w_state_nxt = c_XFER;
                    w_grant_nxt = c_ONE << w_winner;
                    w_owner_nxt = w_winner;
                end
            end
            default: begin
                // Lock is released only by popping the tail flit.
                if (w_pop && w_head[FLIT_WIDTH-1]) begin
                    w_state_nxt = c_IDLE;
                    w_grant_nxt = '0;
                    w_rr_nxt    = r_owner;
                end
            end
        endcase
    end

    always_ff @(posedge router_clk) begin
        if (router_srst) begin
            r_state        <= c_IDLE;
            r_grant        <= '0;
            r_owner        <= '0;
            r_rr_ptr       <= c_LAST_PORT;
            r_egress_write <= 1'b0;
            r_egress_data  <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_grant        <= w_grant_nxt;
            r_owner        <= w_owner_nxt;
            r_rr_ptr       <= w_rr_nxt;
            r_egress_write <= w_pop;
            if (w_pop) r_egress_data <= w_head;
        end
    end

    assign grant        = r_grant;
    assign busy         = (r_state == c_XFER);
    assign egress_write = r_egress_write;
    assign egress_data  = r_egress_data;

endmodule
`default_nettype wire

// File: tb/tb_hynoc_egress_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_hynoc_egress_arbiter
// Description : Directed scenarios plus randomized traffic against a
//               transaction-level reference of the egress arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hynoc_egress_arbiter;

    localparam int NB     = 5;
    localparam int L      = 5;
    localparam int PW     = 32;
    localparam int FW     = PW + 1;
    localparam int MARGIN = 2;
    localparam int DEPTH  = 1 << L;

    logic              router_clk  = 1'b0;
    logic              router_srst = 1'b1;
    logic [NB-1:0]     req_valid   = '0;
    logic [NB*FW-1:0]  req_data    = '0;
    logic [NB-1:0]     req_read;
    logic              egress_write;
    logic [FW-1:0]     egress_data;
    logic [L:0]        egress_fifo_level = '0;
    logic [NB-1:0]     grant;
    logic              busy;

    hynoc_egress_arbiter #(
        .NB_PORTS(NB), .LOG2_FIFO_DEPTH(L), .PAYLOAD_WIDTH(PW),
        .FLIT_WIDTH(FW), .LEVEL_MARGIN(MARGIN)
    ) dut (
        .router_clk(router_clk), .router_srst(router_srst),
        .req_valid(req_valid), .req_data(req_data), .req_read(req_read),
        .egress_write(egress_write), .egress_data(egress_data),
        .egress_fifo_level(egress_fifo_level), .grant(grant), .busy(busy)
    );

    always #5 router_clk = ~router_clk;

    int checks = 0;
    int errors = 0;

    // Ingress FIFOs, held-off ports, and downstream level seen by the DUT.
    logic [FW-1:0] inq [NB][$];
    logic [NB-1:0] hold = '0;
    int            level = 0;
    int            seq = 0;
    logic [FW-1:0] last_pkt [$];

    // Reference: packet owner (-1 when nobody holds the link) and last served port.
    int            m_owner = -1;
    int            m_last  = NB - 1;
    logic [NB-1:0] exp_read, exp_grant;
    logic          exp_write, exp_busy;
    logic [FW-1:0] exp_data;
    logic [NB-1:0] obs_read, obs_grant;
    logic          obs_write, obs_busy;
    logic [FW-1:0] obs_data;
    logic [FW-1:0] eg_log [$];

    task automatic push_pkt(input int port, input int len);
        logic [FW-1:0] f;
        last_pkt.delete();
        for (int j = 0; j < len; j++) begin
            seq++;
            f = {(j == len - 1), 4'(port), 12'(seq), 16'($urandom)};
            inq[port].push_back(f);
            last_pkt.push_back(f);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NB; i++) begin
            req_valid[i] = (inq[i].size() > 0) && !hold[i];
            req_data[i*FW +: FW] = (inq[i].size() > 0) ? inq[i][0] : '0;
        end
        egress_fifo_level = (L+1)'(level);
    endtask

    // One clock: sample req_read mid-cycle, predict, then sample registered outputs.
    task automatic tick();
        int pop_p;
        int win;
        bit space;
        @(negedge router_clk);
        obs_read = req_read;
        space = (DEPTH - level) > MARGIN;
        pop_p = -1;
        win   = -1;
        if (!router_srst && m_owner >= 0 && req_valid[m_owner] && space) pop_p = m_owner;
        exp_read = (pop_p >= 0) ? (NB'(1) << pop_p) : '0;
        if (m_owner < 0)
            for (int k = 1; k <= NB; k++)
                if (win < 0 && req_valid[(m_last + k) % NB]) win = (m_last + k) % NB;
        @(posedge router_clk);
        #1;
        if (router_srst) begin
            m_owner = -1; m_last = NB - 1; exp_write = 1'b0; exp_data = '0;
        end else if (pop_p >= 0) begin
            exp_write = 1'b1;
            exp_data  = inq[pop_p].pop_front();
            if (exp_data[FW-1]) begin m_last = pop_p; m_owner = -1; end
        end else begin
            exp_write = 1'b0;
            if (win >= 0) m_owner = win;
        end
        exp_grant = (m_owner >= 0) ? (NB'(1) << m_owner) : '0;
        exp_busy  = (m_owner >= 0);
        obs_write = egress_write; obs_data = egress_data;
        obs_grant = grant;        obs_busy = busy;
        if (obs_write) eg_log.push_back(obs_data);
        drive();
    endtask

    task automatic do_reset();
        router_srst = 1'b1;
        for (int i = 0; i < NB; i++) inq[i].delete();
        hold = '0; level = 0;
        drive();
        tick(); tick();
        router_srst = 1'b0;
        eg_log.delete();
    endtask

    always @(negedge router_clk) begin
        if (!router_srst) begin
            checks++;
            if (!$onehot0(req_read) || ((req_read & ~req_valid) != '0)) begin
                errors++;
                $display("FAIL read_protocol: req_read=%b req_valid=%b", req_read, req_valid);
            end
            checks++;
            if (!$onehot0(grant) || ((grant == '0) != !busy)) begin
                errors++;
                $display("FAIL grant_protocol: grant=%b busy=%b", grant, busy);
            end
        end
    end

    task automatic test_reset();
        router_srst = 1'b1;
        push_pkt(3, 2);
        drive();
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (obs_read !== '0) begin errors++; $display("FAIL reset_read: got %b want 0", obs_read); end
            checks++;
            if ({obs_write, obs_data, obs_grant, obs_busy} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: write=%b data=%h grant=%b busy=%b want all 0",
                         obs_write, obs_data, obs_grant, obs_busy);
            end
        end
        router_srst = 1'b0;
        tick();
        checks++;
        if (obs_grant !== 5'b01000) begin errors++; $display("FAIL reset_first_grant: got %b want 01000", obs_grant); end
    endtask

    task automatic test_single_packet();
        logic [FW-1:0] pkt [$];
        do_reset();
        push_pkt(2, 3);
        pkt = last_pkt;
        drive();
        tick();
        checks++;
        if (obs_grant !== 5'b00100 || obs_busy !== 1'b1) begin
            errors++; $display("FAIL single_grant: grant=%b busy=%b want 00100/1", obs_grant, obs_busy);
        end
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++;
            if (obs_read !== 5'b00100) begin errors++; $display("FAIL single_read%0d: got %b want 00100", j, obs_read); end
            checks++;
            if (obs_write !== 1'b1 || obs_data !== pkt[j]) begin
                errors++; $display("FAIL single_egress%0d: write=%b data=%h want 1/%h", j, obs_write, obs_data, pkt[j]);
            end
        end
        checks++;
        if (obs_busy !== 1'b0 || obs_grant !== '0) begin
            errors++; $display("FAIL single_release: busy=%b grant=%b want 0/0", obs_busy, obs_grant);
        end
        tick();
        checks++;
        if (obs_read !== '0 || obs_write !== 1'b0) begin
            errors++; $display("FAIL single_after: read=%b write=%b want 0/0", obs_read, obs_write);
        end
    endtask

    task automatic test_round_robin();
        logic [FW-1:0] p0a [$], p0b [$], p3a [$], p3b [$], expq [$];
        logic [11:0]   pat;
        do_reset();
        push_pkt(0, 2); p0a = last_pkt;
        push_pkt(0, 2); p0b = last_pkt;
        push_pkt(3, 2); p3a = last_pkt;
        push_pkt(3, 2); p3b = last_pkt;
        expq = {p0a, p3a, p0b, p3b};
        drive();
        pat = '0;
        for (int c = 0; c < 12; c++) begin
            tick();
            pat = {pat[10:0], obs_write};
        end
        checks++;
        if (pat !== 12'b011011011011) begin errors++; $display("FAIL rr_gap_pattern: got %b want 011011011011", pat); end
        checks++;
        if (eg_log !== expq) begin
            errors++; $display("FAIL rr_order: got %0d flits, first port %0d, want order 0,3,0,3 of 8 flits",
                               eg_log.size(), (eg_log.size() > 0) ? int'(eg_log[0][31:28]) : -1);
        end
    endtask

    task automatic test_backpressure();
        logic [FW-1:0] pkt [$];
        int budget;
        do_reset();
        level = 29;
        push_pkt(0, 6); pkt = last_pkt;
        drive();
        tick(); tick();
        checks++;
        if (obs_read !== 5'b00001) begin errors++; $display("FAIL bp_level29_read: got %b want 00001", obs_read); end
        level = 30; drive();
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (obs_read !== '0 || obs_grant !== 5'b00001 || obs_write !== 1'b0) begin
                errors++; $display("FAIL bp_level30_stall%0d: read=%b grant=%b write=%b want 0/00001/0",
                                   c, obs_read, obs_grant, obs_write);
            end
        end
        level = 40; drive();
        tick();
        checks++;
        if (obs_read !== '0) begin errors++; $display("FAIL bp_overfull_read: got %b want 0", obs_read); end
        level = 10; drive();
        budget = 0;
        while (eg_log.size() < 6 && budget < 30) begin tick(); budget++; end
        checks++;
        if (eg_log !== pkt) begin
            errors++; $display("FAIL bp_resume_data: got %0d flits want 6 in order", eg_log.size());
        end
    endtask

    task automatic test_owner_stall();
        logic [FW-1:0] p1 [$], p4 [$], expq [$];
        int budget;
        do_reset();
        push_pkt(1, 4); p1 = last_pkt;
        push_pkt(4, 2); p4 = last_pkt;
        expq = {p1, p4};
        drive();
        tick(); tick(); tick();
        hold[1] = 1'b1; drive();
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (obs_read !== '0 || obs_grant !== 5'b00010) begin
                errors++; $display("FAIL stall_hold%0d: read=%b grant=%b want 0/00010", c, obs_read, obs_grant);
            end
        end
        hold = '0; drive();
        budget = 0;
        while (eg_log.size() < 6 && budget < 30) begin tick(); budget++; end
        checks++;
        if (eg_log !== expq) begin
            errors++; $display("FAIL stall_order: got %0d flits want port1 x4 then port4 x2", eg_log.size());
        end
    endtask

    task automatic test_all_single();
        do_reset();
        for (int p = 0; p < NB; p++) push_pkt(p, 1);
        drive();
        for (int c = 0; c < 10; c++) tick();
        checks++;
        if (eg_log.size() != NB) begin
            errors++; $display("FAIL single_flits_count: got %0d want %0d in 10 cycles", eg_log.size(), NB);
        end else begin
            for (int j = 0; j < NB; j++) begin
                checks++;
                if (int'(eg_log[j][31:28]) != j || eg_log[j][FW-1] !== 1'b1) begin
                    errors++; $display("FAIL single_flits_slot%0d: port=%0d tail=%b want %0d/1",
                                       j, eg_log[j][31:28], eg_log[j][FW-1], j);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_pkt(2, 4);
        drive();
        tick(); tick();
        push_pkt(0, 1);
        router_srst = 1'b1; drive();
        tick();
        checks++;
        if (obs_read !== '0) begin errors++; $display("FAIL midreset_read: got %b want 0", obs_read); end
        checks++;
        if (obs_write !== 1'b0 || obs_grant !== '0 || obs_busy !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs: write=%b grant=%b busy=%b want 0/0/0", obs_write, obs_grant, obs_busy);
        end
        router_srst = 1'b0; drive();
        tick();
        checks++;
        if (obs_grant !== 5'b00001) begin errors++; $display("FAIL midreset_regrant: got %b want 00001", obs_grant); end
    endtask

    task automatic test_random();
        int p;
        do_reset();
        for (int c = 0; c < 1200; c++) begin
            if ($urandom_range(0, 99) < 20) begin
                p = $urandom_range(0, NB - 1);
                if (inq[p].size() < 16) push_pkt(p, $urandom_range(1, 5));
            end
            level = ($urandom_range(0, 99) < 75) ? $urandom_range(0, 28) : $urandom_range(29, 40);
            for (int i = 0; i < NB; i++) hold[i] = ($urandom_range(0, 99) < 10);
            drive();
            tick();
            checks++;
            if (obs_read !== exp_read) begin errors++; $display("FAIL rand_read@%0d: got %b want %b", c, obs_read, exp_read); end
            checks++;
            if (obs_write !== exp_write || obs_data !== exp_data) begin
                errors++; $display("FAIL rand_egress@%0d: got %b/%h want %b/%h", c, obs_write, obs_data, exp_write, exp_data);
            end
            checks++;
            if (obs_grant !== exp_grant || obs_busy !== exp_busy) begin
                errors++; $display("FAIL rand_grant@%0d: got %b/%b want %b/%b", c, obs_grant, obs_busy, exp_grant, exp_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_owner_stall();
        test_all_single();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
